// File: rtl/ssd_pkg.sv
// Shared definitions for the BCD scanner: converter states, segment codes and sizes.
package ssd_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int NUM_WIDTH  = 13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    // Active-low segments, bit 6 = a ... bit 0 = g
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment decoder with blank override.
module seg7_decode
    import ssd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/ssd_bcd_scanner.sv
// Binary-to-BCD converter (shift-add-3) feeding a 4-digit multiplexed 7-segment scanner.
module ssd_bcd_scanner
    import ssd_pkg::*;
#(
    parameter int REFRESH_BITS = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_WIDTH-1:0] num,
    input  logic                 blank_lz,
    output logic [3:0]           Anode,
    output logic [6:0]           LED_out,
    output logic [15:0]          bcd_out,
    output logic                 busy
);

    localparam logic [3:0] LAST_ITER = 4'(NUM_WIDTH - 1);

    conv_state_t          state;
    conv_state_t          state_next;
    logic [NUM_WIDTH-1:0] shreg;
    logic [15:0]          scratch;
    logic [15:0]          scratch_adj;
    logic [3:0]           count;

    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  state_next = ST_SHIFT;
            ST_SHIFT: if (count == LAST_ITER) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            scratch <= '0;
            count   <= '0;
            bcd_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    shreg   <= num;
                    scratch <= '0;
                    count   <= '0;
                end
                ST_SHIFT: begin
                    scratch <= {scratch_adj[14:0], shreg[NUM_WIDTH-1]};
                    shreg   <= {shreg[NUM_WIDTH-2:0], 1'b0};
                    count   <= count + 4'd1;
                end
                ST_DONE: bcd_out <= scratch;
                default: ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

    // Display scan: reads only the committed bcd_out
    logic [REFRESH_BITS-1:0] scan_cnt;
    logic [1:0]              sel;
    logic [3:0]              digit;
    logic [3:0]              anode_next;
    logic                    blank;
    logic [6:0]              seg_next;
    logic                    thou_zero;
    logic                    hund_zero;
    logic                    tens_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) scan_cnt <= '0;
        else     scan_cnt <= scan_cnt + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
    end

    assign sel       = scan_cnt[REFRESH_BITS-1 -: 2];
    assign thou_zero = (bcd_out[15:12] == 4'd0);
    assign hund_zero = thou_zero && (bcd_out[11:8] == 4'd0);
    assign tens_zero = hund_zero && (bcd_out[7:4] == 4'd0);

    always_comb begin
        digit      = bcd_out[3:0];
        anode_next = 4'b1110;
        blank      = 1'b0;
        case (sel)
            2'd0: begin
                digit      = bcd_out[15:12];
                anode_next = 4'b0111;
                blank      = blank_lz && thou_zero;
            end
            2'd1: begin
                digit      = bcd_out[11:8];
                anode_next = 4'b1011;
                blank      = blank_lz && hund_zero;
            end
            2'd2: begin
                digit      = bcd_out[7:4];
                anode_next = 4'b1101;
                blank      = blank_lz && tens_zero;
            end
            default: begin
                digit      = bcd_out[3:0];
                anode_next = 4'b1110;
                blank      = 1'b0;
            end
        endcase
    end

    seg7_decode u_seg7_decode (
        .digit (digit),
        .blank (blank),
        .seg   (seg_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Anode   <= 4'b1111;
            LED_out <= SEG_BLANK;
        end else begin
            Anode   <= anode_next;
            LED_out <= seg_next;
        end
    end

endmodule

// File: tb/tb_ssd_bcd_scanner.sv
// Scoreboard bench: stimulus pushes decimal expectations, a monitor checks conversions and scan outputs.
module tb_ssd_bcd_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] num = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  Anode;
    logic [6:0]  LED_out;
    logic [15:0] bcd_out;
    logic        busy;

    ssd_bcd_scanner #(.REFRESH_BITS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .num      (num),
        .blank_lz (blank_lz),
        .Anode    (Anode),
        .LED_out  (LED_out),
        .bcd_out  (bcd_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    bit stop_push = 1'b0;

    logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    int div_tab [4] = '{1000, 100, 10, 1};

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int to_bcd(input int d);
        return ((d / 1000) << 12) | (((d / 100) % 10) << 8) | (((d / 10) % 10) << 4) | (d % 10);
    endfunction

    // Monitor: predicts scan outputs from edge count and the last completed value
    int  k = 0;
    int  run = 0;
    bit  prev_busy = 1'b0;
    int  disp = 0;

    always @(posedge clk) begin
        int sel, dig, e;
        logic [3:0] a_exp;
        logic [6:0] l_exp;
        bit ok;
        #1;
        if (rst) begin
            k = 0; run = 0; prev_busy = 1'b0; disp = 0;
            chk("rst_anode", int'(Anode), 4'hF);
            chk("rst_led", int'(LED_out), 7'h7F);
            chk("rst_bcd", int'(bcd_out), 0);
            chk("rst_busy", int'(busy), 0);
        end else begin
            k++;
            sel = ((k - 1) >> 2) & 3;
            a_exp = ~(4'b1000 >> sel);
            dig = (disp / div_tab[sel]) % 10;
            if (blank_lz && sel != 3 && disp < div_tab[sel]) l_exp = 7'h7F;
            else l_exp = seg_tab[dig];
            chk("anode", int'(Anode), int'(a_exp));
            chk("led_out", int'(LED_out), int'(l_exp));
            if (busy) begin
                run++;
            end else if (prev_busy) begin
                chk("busy_len", run, 14);
                run = 0;
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: got bcd 0x%0h, expected no conversion", bcd_out);
                end else begin
                    e = exp_q.pop_front();
                    disp = e;
                    ok = 1'b1;
                    for (int i = 0; i < 4; i++) if (bcd_out[4*i +: 4] > 4'd9) ok = 1'b0;
                    chk("nibble_le9", int'(ok), 1);
                end
            end
            chk("bcd_out", int'(bcd_out), to_bcd(disp));
            prev_busy = busy;
        end
    end

    task automatic drive(input int v, input bit bl);
        @(negedge clk);
        num = 13'(v);
        blank_lz = bl;
        if (!rst && !busy && !stop_push) exp_q.push_back(v);
    endtask

    task automatic release_rst(input int v, input bit bl);
        @(negedge clk);
        rst = 1'b0;
        num = 13'(v);
        blank_lz = bl;
        exp_q.push_back(v);
    endtask

    initial begin
        int rnum;
        bit bl;
        int picks [8] = '{0, 9, 10, 99, 100, 999, 1000, 8191};

        repeat (3) @(negedge clk);
        release_rst(1234, 1'b0);
        repeat (46) drive(1234, 1'b0);

        repeat (15) drive(8191, 1'b0);
        repeat (30) drive(0, 1'b0);

        repeat (35) drive(7, 1'b1);
        repeat (35) drive(0, 1'b1);

        drive(100, 1'b0);
        while (!busy) drive(100, 1'b0);
        repeat (4) drive(100, 1'b0);
        repeat (40) drive(200, 1'b0);

        while (!busy) drive(200, 1'b0);
        repeat (3) drive(200, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("pulse_anode", int'(Anode), 4'hF);
        chk("pulse_led", int'(LED_out), 7'h7F);
        chk("pulse_bcd", int'(bcd_out), 0);
        @(negedge clk);
        release_rst(4321, 1'b1);
        repeat (40) drive(4321, 1'b1);

        rnum = 0;
        bl = 1'b0;
        repeat (450) begin
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 2) == 0) rnum = picks[$urandom_range(0, 7)];
                else rnum = int'($urandom_range(0, 8191));
            end
            if ($urandom_range(0, 31) == 0) bl = ~bl;
            drive(rnum, bl);
        end

        stop_push = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain: got %0d pending conversions, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
